// File: rtl/adc_paddle_reader.sv
// adc_paddle_reader
//   Drives the dual-channel serial A/D converter that digitizes both paddle
//   potentiometers. A free-running sample timer periodically starts a
//   conversion. The block then shifts NBITS bits from each channel in
//   parallel over the two DOUT lines, MSB first. The upper 8 bits of each
//   channel are presented to the Nios PIO inputs together with a BUSY flag.
//
// Ports
//   clock_50MHz  in   system clock, rising edge
//   RESET_n      in   asynchronous active-low reset
//   ADC_DOUT     in   [1:0] serial data, bit0 = channel 0, bit1 = channel 1
//   ADC_CNVST    out  conversion start, active low
//   ADC_CS_N     out  chip select, active low
//   ADC_SCLK     out  serial clock, idles high
//   ADC_REFSEL   out  tied 0 (internal reference)
//   ADC_SD       out  tied 0 (single-ended)
//   ADC_UB       out  tied 0 (unipolar)
//   ADC_SEL      out  tied 0 (channel pair 0)
//   BUSY         out  high while a frame is in progress
//   DATA_VALID   out  one-cycle pulse when DATA_AD0/1 update
//   DATA_AD0     out  [7:0] paddle 1 value
//   DATA_AD1     out  [7:0] paddle 2 value
module adc_paddle_reader #(
   parameter int CLK_DIV       = 25,
   parameter int NBITS         = 12,
   parameter int CNV_PULSE     = 4,
   parameter int CONV_WAIT     = 200,
   parameter int SAMPLE_PERIOD = 500000
) (
   input  logic       clock_50MHz,
   input  logic       RESET_n,
   input  logic [1:0] ADC_DOUT,
   output logic       ADC_CNVST,
   output logic       ADC_CS_N,
   output logic       ADC_SCLK,
   output logic       ADC_REFSEL,
   output logic       ADC_SD,
   output logic       ADC_UB,
   output logic       ADC_SEL,
   output logic       BUSY,
   output logic       DATA_VALID,
   output logic [7:0] DATA_AD0,
   output logic [7:0] DATA_AD1
);

   localparam int WAIT_MAX = (CONV_WAIT > CNV_PULSE) ? CONV_WAIT : CNV_PULSE;
   localparam int TMR_W    = $clog2(SAMPLE_PERIOD);
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam int DIV_W    = $clog2(CLK_DIV + 1);
   localparam int BIT_W    = $clog2(NBITS + 1);

   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SAMPLE_PERIOD - 1);
   localparam logic [WAIT_W-1:0] CNV_LAST  = WAIT_W'(CNV_PULSE - 1);
   localparam logic [WAIT_W-1:0] CONV_LAST = WAIT_W'(CONV_WAIT - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      CONV,
      SHIFT,
      LATCH
   } state_t;

   state_t             state_q, state_nx;
   logic [TMR_W-1:0]   tmr_q;
   logic [WAIT_W-1:0]  wait_q;
   logic [DIV_W-1:0]   div_q;
   logic [BIT_W-1:0]   bit_q;
   logic               sclk_q;
   logic [NBITS-1:0]   sr0_q, sr1_q;
   logic [1:0]         dout_p0, dout_p1;
   logic               cnvst_q, cs_n_q, busy_q, valid_q;
   logic [7:0]         ad0_q, ad1_q;

   logic               tmr_wrap, sclk_tick, sclk_rise;
   logic               cnvst_nx, cs_n_nx, busy_nx;

   assign tmr_wrap  = (tmr_q == TMR_LAST);
   assign sclk_tick = (div_q == DIV_LAST);
   // A toggle while SCLK is low is a rising edge: the sampling point.
   assign sclk_rise = (state_q == SHIFT) && sclk_tick && !sclk_q;

   // Next state and next-cycle pin levels. The pins are registered from the
   // next state so the off-chip ADC never sees decode glitches.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (tmr_wrap)                         state_nx = START;
         START:   if (wait_q == CNV_LAST)               state_nx = CONV;
         CONV:    if (wait_q == CONV_LAST)              state_nx = SHIFT;
         SHIFT:   if (sclk_rise && (bit_q == BIT_LAST)) state_nx = LATCH;
         LATCH:                                         state_nx = IDLE;
         default:                                       state_nx = IDLE;
      endcase
      cnvst_nx = (state_nx != START);
      cs_n_nx  = !((state_nx == SHIFT) || (state_nx == LATCH));
      busy_nx  = (state_nx != IDLE);
   end

   always_ff @(posedge clock_50MHz or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         wait_q  <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b1;
         sr0_q   <= '0;
         sr1_q   <= '0;
         dout_p0 <= '0;
         dout_p1 <= '0;
         cnvst_q <= 1'b1;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         ad0_q   <= '0;
         ad1_q   <= '0;
      end else begin
         // stage p0/p1: two-flop synchronizer on the asynchronous DOUT lines
         dout_p0 <= ADC_DOUT;
         dout_p1 <= dout_p0;

         // Timer runs regardless of state; a wrap outside IDLE is ignored.
         tmr_q   <= tmr_wrap ? '0 : tmr_q + 1'b1;
         state_q <= state_nx;

         if ((state_nx == state_q) && ((state_q == START) || (state_q == CONV)))
            wait_q <= wait_q + 1'b1;
         else
            wait_q <= '0;

         if (state_q == SHIFT) begin
            div_q <= sclk_tick ? '0 : div_q + 1'b1;
            if (sclk_tick)
               sclk_q <= !sclk_q;
         end else begin
            div_q  <= '0;
            sclk_q <= 1'b1;
         end

         if (state_q != SHIFT)
            bit_q <= '0;
         else if (sclk_rise)
            bit_q <= bit_q + 1'b1;

         if (sclk_rise) begin
            sr0_q <= {sr0_q[NBITS-2:0], dout_p1[0]};
            sr1_q <= {sr1_q[NBITS-2:0], dout_p1[1]};
         end

         // Both channels update together, and only from a complete frame.
         if (state_q == LATCH) begin
            ad0_q <= sr0_q[NBITS-1 -: 8];
            ad1_q <= sr1_q[NBITS-1 -: 8];
         end
         valid_q <= (state_q == LATCH);

         cnvst_q <= cnvst_nx;
         cs_n_q  <= cs_n_nx;
         busy_q  <= busy_nx;
      end
   end

   assign ADC_CNVST  = cnvst_q;
   assign ADC_CS_N   = cs_n_q;
   assign ADC_SCLK   = sclk_q;
   assign ADC_REFSEL = 1'b0;
   assign ADC_SD     = 1'b0;
   assign ADC_UB     = 1'b0;
   assign ADC_SEL    = 1'b0;
   assign BUSY       = busy_q;
   assign DATA_VALID = valid_q;
   assign DATA_AD0   = ad0_q;
   assign DATA_AD1   = ad1_q;

endmodule

// File: tb/tb_adc_paddle_reader.sv
// tb_adc_paddle_reader
//   Bench for adc_paddle_reader with a shortened sample period. A behavioural
//   ADC presents one bit per SCLK falling edge, MSB first. Expected paddle
//   values are queued when a frame's samples are handed to the ADC model and
//   are compared when DATA_VALID pulses. Frame timing is measured by a
//   monitor on the falling clock edge.
module tb_adc_paddle_reader;

   localparam int CLK_DIV   = 25;
   localparam int NBITS     = 12;
   localparam int CNV_PULSE = 4;
   localparam int CONV_WAIT = 200;
   localparam int SP        = 1000;
   localparam int FRAME_LEN = CNV_PULSE + CONV_WAIT + NBITS * 2 * CLK_DIV + 1;

   logic       clock_50MHz = 1'b0;
   logic       RESET_n;
   logic [1:0] ADC_DOUT;
   logic       ADC_CNVST, ADC_CS_N, ADC_SCLK;
   logic       ADC_REFSEL, ADC_SD, ADC_UB, ADC_SEL;
   logic       BUSY, DATA_VALID;
   logic [7:0] DATA_AD0, DATA_AD1;

   adc_paddle_reader #(
      .CLK_DIV       (CLK_DIV),
      .NBITS         (NBITS),
      .CNV_PULSE     (CNV_PULSE),
      .CONV_WAIT     (CONV_WAIT),
      .SAMPLE_PERIOD (SP)
   ) dut (
      .clock_50MHz (clock_50MHz),
      .RESET_n     (RESET_n),
      .ADC_DOUT    (ADC_DOUT),
      .ADC_CNVST   (ADC_CNVST),
      .ADC_CS_N    (ADC_CS_N),
      .ADC_SCLK    (ADC_SCLK),
      .ADC_REFSEL  (ADC_REFSEL),
      .ADC_SD      (ADC_SD),
      .ADC_UB      (ADC_UB),
      .ADC_SEL     (ADC_SEL),
      .BUSY        (BUSY),
      .DATA_VALID  (DATA_VALID),
      .DATA_AD0    (DATA_AD0),
      .DATA_AD1    (DATA_AD1)
   );

   always #10 clock_50MHz = ~clock_50MHz;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // {ch1, ch0} samples per frame, and expected {DATA_AD1, DATA_AD0}
   logic [23:0] stim_q[$];
   logic [15:0] exp_q[$];

   // ADC model: a frame's samples are taken at CNVST fall, one bit is
   // driven per SCLK falling edge while selected.
   logic [NBITS-1:0] cur0, cur1;
   int               bidx;

   always @(negedge ADC_CNVST) begin
      logic [23:0] s;
      s = (stim_q.size() > 0) ? stim_q.pop_front() : 24'h0;
      cur0 = s[11:0];
      cur1 = s[23:12];
      bidx = NBITS - 1;
      exp_q.push_back({cur1[NBITS-1 -: 8], cur0[NBITS-1 -: 8]});
   end

   always @(negedge ADC_SCLK) begin
      if (ADC_CS_N === 1'b0 && bidx >= 0) begin
         ADC_DOUT = {cur1[bidx], cur0[bidx]};
         bidx--;
      end
   end

   // Frame-timing monitor and scoreboard
   int   cyc = 0;
   int   busy_len = 0, cnv_len = 0, conv_len = 0, rise_cnt = 0;
   int   last_rise = 0, last_valid = 0, valid_cnt = 0;
   bit   has_prev_v = 0, sclk_bad = 0, data_glitch = 0, dv_wide = 0;
   logic p_busy = 0, p_cnvst = 1, p_cs = 1, p_sclk = 1, p_dv = 0;
   logic [7:0] p_ad0 = 0, p_ad1 = 0;

   always @(negedge clock_50MHz) begin
      logic [15:0] e;
      cyc++;
      if (!RESET_n) begin
         busy_len   = 0;
         cnv_len    = 0;
         conv_len   = 0;
         rise_cnt   = 0;
         has_prev_v = 0;
      end else begin
         if (BUSY) busy_len++;
         else if (p_busy) begin
            check("busy_len", busy_len, FRAME_LEN);
            busy_len = 0;
         end
         if (!ADC_CNVST) cnv_len++;
         else if (!p_cnvst) begin
            check("cnvst_len", cnv_len, CNV_PULSE);
            cnv_len = 0;
         end
         if (BUSY && ADC_CNVST && ADC_CS_N) conv_len++;
         if (!ADC_CS_N && p_cs) begin
            check("conv_wait", conv_len, CONV_WAIT);
            conv_len = 0;
            rise_cnt = 0;
         end
         if (!ADC_CS_N && ADC_SCLK && !p_sclk) begin
            rise_cnt++;
            if (rise_cnt > 1) check("sclk_period", cyc - last_rise, 2 * CLK_DIV);
            last_rise = cyc;
         end
         if (ADC_CS_N && !p_cs) check("sclk_rises", rise_cnt, NBITS);
         if (ADC_CS_N && !ADC_SCLK) sclk_bad = 1;
         if (DATA_VALID) begin
            valid_cnt++;
            if (p_dv) dv_wide = 1;
            if (has_prev_v) check("valid_gap", cyc - last_valid, SP);
            has_prev_v = 1;
            last_valid = cyc;
            check("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("data_ad0", DATA_AD0, e[7:0]);
               check("data_ad1", DATA_AD1, e[15:8]);
            end
         end else if (DATA_AD0 !== p_ad0 || DATA_AD1 !== p_ad1) begin
            data_glitch = 1;
         end
      end
      p_busy  = BUSY;
      p_cnvst = ADC_CNVST;
      p_cs    = ADC_CS_N;
      p_sclk  = ADC_SCLK;
      p_dv    = DATA_VALID;
      p_ad0   = DATA_AD0;
      p_ad1   = DATA_AD1;
   end

   task automatic wait_valid(input int target, input int budget);
      int t = 0;
      while (valid_cnt < target && t < budget) begin
         @(negedge clock_50MHz);
         t++;
      end
      check("valid_count", valid_cnt, target);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  BUSY,       1'b0);
      check({tag, "_cnvst"}, ADC_CNVST,  1'b1);
      check({tag, "_cs_n"},  ADC_CS_N,   1'b1);
      check({tag, "_sclk"},  ADC_SCLK,   1'b1);
      check({tag, "_dv"},    DATA_VALID, 1'b0);
      check({tag, "_ad0"},   DATA_AD0,   8'h00);
      check({tag, "_ad1"},   DATA_AD1,   8'h00);
   endtask

   initial begin
      int   t;
      int   r;
      logic sp;
      RESET_n  = 1'b0;
      ADC_DOUT = 2'b00;
      stim_q.push_back(24'h3C0_A5F);
      stim_q.push_back(24'h000_FFF);
      stim_q.push_back(24'hFFF_000);
      stim_q.push_back(24'h7FF_800);
      stim_q.push_back(24'hFED_123);
      stim_q.push_back(24'hAAA_555);   // aborted by reset
      stim_q.push_back(24'h1E4_6B2);
      stim_q.push_back(24'hE38_9C7);

      repeat (5) @(negedge clock_50MHz);
      check_reset_outputs("rst");
      check("refsel", ADC_REFSEL, 1'b0);
      check("sd",     ADC_SD,     1'b0);
      check("ub",     ADC_UB,     1'b0);
      check("sel",    ADC_SEL,    1'b0);

      RESET_n = 1'b1;
      repeat (SP - 1) @(posedge clock_50MHz);
      @(negedge clock_50MHz);
      check_reset_outputs("pre_frame");
      @(posedge clock_50MHz);
      @(negedge clock_50MHz);
      check("first_cnvst", ADC_CNVST, 1'b0);
      check("first_busy",  BUSY,      1'b1);

      wait_valid(5, 6 * SP);

      // Abort the sixth frame during its sixth bit.
      t = 0;
      while (ADC_CS_N !== 1'b0 && t < 2 * SP) begin
         @(negedge clock_50MHz);
         t++;
      end
      check("abort_cs_low", ADC_CS_N, 1'b0);
      r  = 0;
      sp = ADC_SCLK;
      t  = 0;
      while (r < 6 && t < 2 * SP) begin
         @(negedge clock_50MHz);
         if (ADC_SCLK && !sp) r++;
         sp = ADC_SCLK;
         t++;
      end
      check("abort_reach_bit6", r, 6);
      repeat (10) @(negedge clock_50MHz);
      #3 RESET_n = 1'b0;
      #1 check_reset_outputs("abort");
      check("abort_pending", exp_q.size(), 1);
      exp_q.delete();
      repeat (5) @(negedge clock_50MHz);
      RESET_n = 1'b1;

      wait_valid(7, 3 * SP);
      repeat (10) @(negedge clock_50MHz);
      check("sb_empty",     exp_q.size(),  0);
      check("stim_used",    stim_q.size(), 0);
      check("sclk_idle_hi", sclk_bad,      1'b0);
      check("no_partial",   data_glitch,   1'b0);
      check("dv_one_cycle", dv_wide,       1'b0);
      check("valid_total",  valid_cnt,     7);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
